bank_isu_piq: RTL and testbench
===============================

BANK_ISU_PIQ -- requirements
Module: bank_isu_piq

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 3, log2 of queue depth (DEPTH = 2^PTR_WIDTH).
REQ-002 SHALL have parameter CH_NUM, default 3, number of requesting channels (CH_W = max(1,clog2(CH_NUM))).
REQ-003 SHALL have parameter CREDIT_MAX, default 4, per-channel read credit count, range 1..15.
REQ-004 SHALL have parameter RID_WIDTH, default 6, linefill return tag width.
REQ-005 SHALL have parameter PAYLOAD_WIDTH, default 20, opaque entry payload (rob id, set/way/offset, wbuffer id, line state).
REQ-006 SHALL have clk_i  in  1  single clock, and all state SHALL be in this one clock domain.
REQ-007 SHALL have rst_i  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have req_valid_i in 1 enqueue request; req_ready_o out 1 queue can accept.
REQ-009 SHALL have req_op_i in 2 (0 write, 1 read, 2 read+linefill, 3 writeback/evict); req_ch_id_i in CH_W source channel; req_payload_i in PAYLOAD_WIDTH.
REQ-010 SHALL have req_wait_i in 1 entry blocked on linefill; req_wait_rid_i in RID_WIDTH tag it waits on.
REQ-011 SHALL have biu_rvalid_i in 1 and biu_rid_i in RID_WIDTH, linefill return.
REQ-012 SHALL have iss_valid_o out 1, iss_ready_i in 1, iss_op_o out 2, iss_ch_id_o out CH_W, iss_payload_o out PAYLOAD_WIDTH, iss_ptr_o out PTR_WIDTH.
REQ-013 SHALL have credit_release_i in CH_NUM, one credit returned per set bit per cycle.
REQ-014 SHALL have occupancy_o out PTR_WIDTH+1, allocated-not-retired entry count.

Function
REQ-015 SHALL accept (alloc) when req_valid_i & req_ready_o; req_ready_o = (occupancy != DEPTH), combinational from registers only.
REQ-016 SHALL write alloc into slot alloc_ptr, set valid, then alloc_ptr += 1 mod DEPTH.
REQ-017 SHALL clear an entry's wait bit when biu_rvalid_i and biu_rid_i equals its rid; an alloc whose rid matches biu in the same cycle SHALL be stored with wait=0.
REQ-018 SHALL keep per-channel credit counters; entry ready = valid & (op==3 | (~wait & (op==0 | credit[ch]!=0))).
REQ-019 SHALL select the oldest ready entry, scanning from bottom_ptr upward with wrap; iss_valid_o = any ready; iss_* driven from selected slot same cycle.
REQ-020 SHALL on issue (iss_valid_o & iss_ready_i) clear selected valid; op 1 or 2 decrements credit[ch].
REQ-021 SHALL increment credit[c] on credit_release_i[c], saturating at CREDIT_MAX; same-cycle issue-decrement and release on one channel leave it unchanged.
REQ-022 SHALL retire one slot per cycle: if occupancy!=0 and slot bottom_ptr invalid, bottom_ptr += 1 mod DEPTH and occupancy -= 1.
REQ-023 SHALL leave occupancy unchanged on simultaneous alloc and retire; full queue SHALL block alloc until a retire, even if issued entries exist.
REQ-024 SHALL issue an entry at earliest the cycle after its alloc; retire of a slot at earliest the cycle after its issue.
REQ-025 SHALL hold iss_* stable only while selection unchanged; no stability guarantee after iss_valid_o drops (consumer samples on handshake).

Reset
REQ-026 SHALL on rst_i: all valid/wait bits 0, alloc_ptr=bottom_ptr=0, occupancy 0, credits CREDIT_MAX.
REQ-027 SHALL give outputs under reset: req_ready_o=1, iss_valid_o=0, occupancy_o=0; iss_op/ch/payload/ptr don't-care.
REQ-028 SHALL discard in-flight entries on reset mid-operation; no issue in first cycle after deassert.

Structure
REQ-029 SHALL take opcode constants (OP_WR, OP_RD, OP_RD_LF, OP_WB) and credit width from shared package bank_isu_pkg.
REQ-030 SHALL place the wrap-around oldest-first selector in sub-module bank_isu_age_arb (inputs ready vector, bottom_ptr; outputs grant valid, index).

Verification
REQ-031 SHALL cover: 8 writes back-to-back, iss_ready_i=1 -> issued in order ptr 0..7, 9th req held (req_ready_o=0) until first retire, occupancy_o peaks 8.
REQ-032 SHALL cover: CREDIT_MAX=4, 6 reads ch1, no release -> 4 issued, 2 held; pulse credit_release_i[1] twice -> remaining 2 issue.
REQ-033 SHALL cover: read+linefill rid=5 at slot 0, write slot 1 -> slot 1 issues first; biu rid=5 -> slot 0 issues next cycle; bottom_ptr retires both.
REQ-034 SHALL cover: evict (op 3) on channel with credit 0 and wait=1 -> issues immediately, credit unchanged.
REQ-035 SHALL cover: alloc at slot 7 wraps to 0 with bottom_ptr=3; ready in slots 1 and 5 -> slot 5 selected (older).
REQ-036 SHALL cover: rst_i asserted with 5 valid entries -> next cycle iss_valid_o=0, req_ready_o=1, occupancy_o=0, credits full.

Source files
------------

// File: rtl/bank_isu_pkg.sv
// Shared opcode encodings and credit sizing for the bank issue queue.
package bank_isu_pkg;

    localparam logic [1:0] OP_WR    = 2'd0;
    localparam logic [1:0] OP_RD    = 2'd1;
    localparam logic [1:0] OP_RD_LF = 2'd2;
    localparam logic [1:0] OP_WB    = 2'd3;

    // Wide enough for any credit budget up to 15.
    localparam int CREDIT_W = 4;

    function automatic logic is_read(input logic [1:0] op);
        return (op == OP_RD) || (op == OP_RD_LF);
    endfunction

endpackage

// File: rtl/bank_isu_age_arb.sv
// Oldest-first selector over a circular queue, starting from the retire pointer.
module bank_isu_age_arb #(
    parameter  int PTR_WIDTH = 3,
    localparam int DEPTH     = 1 << PTR_WIDTH
) (
    input  logic [DEPTH-1:0]     ready_i,
    input  logic [PTR_WIDTH-1:0] bottom_ptr_i,
    output logic                 gnt_valid_o,
    output logic [PTR_WIDTH-1:0] gnt_idx_o
);

    logic [PTR_WIDTH-1:0] idx;

    // Walk youngest to oldest so the last hit is the oldest ready slot.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        idx         = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx = bottom_ptr_i + PTR_WIDTH'(i);
            if (ready_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = idx;
            end
        end
    end

endmodule

// File: rtl/bank_isu_piq.sv
// Bank issue queue: in-order alloc/retire ring with out-of-order, credit- and
// linefill-gated issue of the oldest ready entry.
module bank_isu_piq
    import bank_isu_pkg::*;
#(
    parameter  int PTR_WIDTH     = 3,
    parameter  int CH_NUM        = 3,
    parameter  int CREDIT_MAX    = 4,
    parameter  int RID_WIDTH     = 6,
    parameter  int PAYLOAD_WIDTH = 20,
    localparam int DEPTH         = 1 << PTR_WIDTH,
    localparam int CH_W          = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_op_i,
    input  logic [CH_W-1:0]          req_ch_id_i,
    input  logic [PAYLOAD_WIDTH-1:0] req_payload_i,
    input  logic                     req_wait_i,
    input  logic [RID_WIDTH-1:0]     req_wait_rid_i,
    input  logic                     biu_rvalid_i,
    input  logic [RID_WIDTH-1:0]     biu_rid_i,
    output logic                     iss_valid_o,
    input  logic                     iss_ready_i,
    output logic [1:0]               iss_op_o,
    output logic [CH_W-1:0]          iss_ch_id_o,
    output logic [PAYLOAD_WIDTH-1:0] iss_payload_o,
    output logic [PTR_WIDTH-1:0]     iss_ptr_o,
    input  logic [CH_NUM-1:0]        credit_release_i,
    output logic [PTR_WIDTH:0]       occupancy_o
);

    localparam logic [PTR_WIDTH:0]   OCC_FULL    = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   OCC_ONE     = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE     = PTR_WIDTH'(1);
    localparam logic [CREDIT_W-1:0]  CREDIT_FULL = CREDIT_W'(CREDIT_MAX);
    localparam logic [CREDIT_W-1:0]  CREDIT_ONE  = CREDIT_W'(1);

    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0]         wait_q, wait_d;
    logic [DEPTH-1:0]         credit_ok, slot_ready;
    logic [1:0]               op_q      [DEPTH];
    logic [CH_W-1:0]          ch_q      [DEPTH];
    logic [RID_WIDTH-1:0]     rid_q     [DEPTH];
    logic [PAYLOAD_WIDTH-1:0] payload_q [DEPTH];
    logic [PTR_WIDTH-1:0]     alloc_ptr_q, alloc_ptr_d;
    logic [PTR_WIDTH-1:0]     bottom_ptr_q, bottom_ptr_d;
    logic [PTR_WIDTH:0]       occ_q, occ_d;
    logic [CREDIT_W-1:0]      credit_q [CH_NUM];
    logic [CREDIT_W-1:0]      credit_d [CH_NUM];

    logic                 alloc, fire, retire, alloc_wait, iss_is_read;
    logic                 gnt_valid;
    logic [PTR_WIDTH-1:0] gnt_idx;

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high; req_ready_o depends only on registers, iss_valid_o never waits on
    // iss_ready_i, and a raised valid may still change or drop before transfer.
    assign req_ready_o = (occ_q != OCC_FULL);
    assign alloc       = req_valid_i & req_ready_o;
    assign fire        = gnt_valid & iss_ready_i;
    assign retire      = (occ_q != '0) & ~valid_q[bottom_ptr_q];
    assign alloc_wait  = req_wait_i & ~(biu_rvalid_i & (biu_rid_i == req_wait_rid_i));
    assign iss_is_read = fire & is_read(op_q[gnt_idx]);

    always_comb begin
        credit_ok  = '0;
        slot_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (ch_q[i] == CH_W'(c)) credit_ok[i] = (credit_q[c] != '0);
            end
            slot_ready[i] = valid_q[i] & ((op_q[i] == OP_WB) |
                            (~wait_q[i] & ((op_q[i] == OP_WR) | credit_ok[i])));
        end
    end

    bank_isu_age_arb #(
        .PTR_WIDTH (PTR_WIDTH)
    ) u_age_arb (
        .ready_i      (slot_ready),
        .bottom_ptr_i (bottom_ptr_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_idx_o    (gnt_idx)
    );

    assign iss_valid_o   = gnt_valid;
    assign iss_op_o      = op_q[gnt_idx];
    assign iss_ch_id_o   = ch_q[gnt_idx];
    assign iss_payload_o = payload_q[gnt_idx];
    assign iss_ptr_o     = gnt_idx;
    assign occupancy_o   = occ_q;

    always_comb begin
        valid_d = valid_q;
        wait_d  = wait_q;
        if (biu_rvalid_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rid_q[i] == biu_rid_i) wait_d[i] = 1'b0;
            end
        end
        if (fire) valid_d[gnt_idx] = 1'b0;
        // The freshly allocated slot overrides any stale match on its old tag.
        if (alloc) begin
            valid_d[alloc_ptr_q] = 1'b1;
            wait_d[alloc_ptr_q]  = alloc_wait;
        end

        alloc_ptr_d  = alloc  ? alloc_ptr_q + PTR_ONE  : alloc_ptr_q;
        bottom_ptr_d = retire ? bottom_ptr_q + PTR_ONE : bottom_ptr_q;
        occ_d = occ_q;
        if (alloc & ~retire)      occ_d = occ_q + OCC_ONE;
        else if (~alloc & retire) occ_d = occ_q - OCC_ONE;

        for (int c = 0; c < CH_NUM; c++) begin
            credit_d[c] = credit_q[c];
            if (credit_release_i[c] & ~(iss_is_read & (iss_ch_id_o == CH_W'(c)))) begin
                if (credit_q[c] != CREDIT_FULL) credit_d[c] = credit_q[c] + CREDIT_ONE;
            end else if (~credit_release_i[c] & iss_is_read & (iss_ch_id_o == CH_W'(c))) begin
                credit_d[c] = credit_q[c] - CREDIT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= '0;
            wait_q       <= '0;
            alloc_ptr_q  <= '0;
            bottom_ptr_q <= '0;
            occ_q        <= '0;
            for (int c = 0; c < CH_NUM; c++) credit_q[c] <= CREDIT_FULL;
        end else begin
            valid_q      <= valid_d;
            wait_q       <= wait_d;
            alloc_ptr_q  <= alloc_ptr_d;
            bottom_ptr_q <= bottom_ptr_d;
            occ_q        <= occ_d;
            for (int c = 0; c < CH_NUM; c++) credit_q[c] <= credit_d[c];
        end
    end

    // Entry contents are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            op_q[alloc_ptr_q]      <= req_op_i;
            ch_q[alloc_ptr_q]      <= req_ch_id_i;
            rid_q[alloc_ptr_q]     <= req_wait_rid_i;
            payload_q[alloc_ptr_q] <= req_payload_i;
        end
    end

endmodule

// File: tb/tb_bank_isu_piq.sv
// Directed bench for bank_isu_piq: ordering, credits, linefill wait, evict, wrap, reset.
module tb_bank_isu_piq;
    import bank_isu_pkg::*;

    localparam int PTR_WIDTH     = 3;
    localparam int CH_NUM        = 3;
    localparam int CREDIT_MAX    = 4;
    localparam int RID_WIDTH     = 6;
    localparam int PAYLOAD_WIDTH = 20;
    localparam int CH_W          = 2;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic                     req_valid_i, req_ready_o;
    logic [1:0]               req_op_i;
    logic [CH_W-1:0]          req_ch_id_i;
    logic [PAYLOAD_WIDTH-1:0] req_payload_i;
    logic                     req_wait_i;
    logic [RID_WIDTH-1:0]     req_wait_rid_i;
    logic                     biu_rvalid_i;
    logic [RID_WIDTH-1:0]     biu_rid_i;
    logic                     iss_valid_o, iss_ready_i;
    logic [1:0]               iss_op_o;
    logic [CH_W-1:0]          iss_ch_id_o;
    logic [PAYLOAD_WIDTH-1:0] iss_payload_o;
    logic [PTR_WIDTH-1:0]     iss_ptr_o;
    logic [CH_NUM-1:0]        credit_release_i;
    logic [PTR_WIDTH:0]       occupancy_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [PAYLOAD_WIDTH-1:0] exp_q[$];
    logic [PTR_WIDTH-1:0]     exp_ptr_q[$];

    always #5 clk_i = ~clk_i;

    bank_isu_piq #(
        .PTR_WIDTH(PTR_WIDTH), .CH_NUM(CH_NUM), .CREDIT_MAX(CREDIT_MAX),
        .RID_WIDTH(RID_WIDTH), .PAYLOAD_WIDTH(PAYLOAD_WIDTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_ch_id_i(req_ch_id_i), .req_payload_i(req_payload_i),
        .req_wait_i(req_wait_i), .req_wait_rid_i(req_wait_rid_i),
        .biu_rvalid_i(biu_rvalid_i), .biu_rid_i(biu_rid_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i), .iss_op_o(iss_op_o),
        .iss_ch_id_o(iss_ch_id_o), .iss_payload_o(iss_payload_o), .iss_ptr_o(iss_ptr_o),
        .credit_release_i(credit_release_i), .occupancy_o(occupancy_o)
    );

    // ---------------- driver tasks ----------------
    task automatic idle();
        req_valid_i = 1'b0; req_op_i = 2'd0; req_ch_id_i = '0; req_payload_i = '0;
        req_wait_i = 1'b0; req_wait_rid_i = '0; biu_rvalid_i = 1'b0; biu_rid_i = '0;
        credit_release_i = '0;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [CH_W-1:0] ch,
                             input logic [PAYLOAD_WIDTH-1:0] pay, input logic w,
                             input logic [RID_WIDTH-1:0] rid);
        idle();
        req_valid_i = 1'b1; req_op_i = op; req_ch_id_i = ch; req_payload_i = pay;
        req_wait_i = w; req_wait_rid_i = rid;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        idle();
        iss_ready_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        for (int c = 0; c < 20 && occupancy_o != '0; c++) begin
            @(negedge clk_i);
            idle();
            #1;
        end
        n_checks++;
        if (occupancy_o !== 4'd0) $display("FAIL %s_drain: occupancy %0d, want 0", name, occupancy_o);
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        iss_ready_i = 1'b1;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        n_checks++;
        if (req_ready_o !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready_o); else n_pass++;
        n_checks++;
        if (iss_valid_o !== 1'b0) $display("FAIL reset_iss_valid: got %b want 0", iss_valid_o); else n_pass++;
        n_checks++;
        if (occupancy_o !== 4'd0) $display("FAIL reset_occ: got %0d want 0", occupancy_o); else n_pass++;
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        n_checks++;
        if (iss_valid_o !== 1'b0) $display("FAIL reset_release_iss: got %b want 0", iss_valid_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc_cycle;
        apply_reset();
        exp_q.delete(); exp_ptr_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            drive_req(OP_WR, 2'd0, PAYLOAD_WIDTH'(32'h100 + i), 1'b0, '0);
            exp_q.push_back(PAYLOAD_WIDTH'(32'h100 + i));
            exp_ptr_q.push_back(PTR_WIDTH'(i));
        end
        @(negedge clk_i);
        drive_req(OP_WR, 2'd0, 20'h1ff, 1'b0, '0);
        #1;
        n_checks++;
        if (occupancy_o !== 4'd8) $display("FAIL b2b_peak_occ: got %0d want 8", occupancy_o); else n_pass++;
        n_checks++;
        if (req_ready_o !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", req_ready_o); else n_pass++;
        n_checks++;
        if ({iss_valid_o, iss_ptr_o} !== 4'b1000)
            $display("FAIL b2b_head: valid/ptr %b/%0d want 1/0", iss_valid_o, iss_ptr_o);
        else n_pass++;
        exp_q.push_back(20'h1ff);
        exp_ptr_q.push_back(3'd0);
        acc_cycle = -1;
        for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
            @(negedge clk_i);
            iss_ready_i = 1'b1;
            if (acc_cycle >= 0) req_valid_i = 1'b0;
            #1;
            if (req_valid_i && req_ready_o) acc_cycle = cyc;
            if (iss_valid_o) begin
                n_checks++;
                if (iss_ptr_o !== exp_ptr_q[0] || iss_payload_o !== exp_q[0])
                    $display("FAIL b2b_order: ptr/payload %0d/%h want %0d/%h",
                             iss_ptr_o, iss_payload_o, exp_ptr_q[0], exp_q[0]);
                else n_pass++;
                void'(exp_q.pop_front());
                void'(exp_ptr_q.pop_front());
            end
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL b2b_all_issued: %0d left want 0", exp_q.size()); else n_pass++;
        n_checks++;
        if (acc_cycle != 2) $display("FAIL b2b_ninth_accept: cycle %0d want 2", acc_cycle); else n_pass++;
        wait_empty("b2b");
    endtask

    task automatic test_credits();
        apply_reset();
        iss_ready_i = 1'b1;
        exp_ptr_q.delete();
        for (int i = 0; i < 4; i++) exp_ptr_q.push_back(PTR_WIDTH'(i));
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk_i);
            if (cyc < 6) drive_req(OP_RD, 2'd1, PAYLOAD_WIDTH'(32'h200 + cyc), 1'b0, '0);
            else idle();
            #1;
            if (iss_valid_o) begin
                n_checks++;
                if (exp_ptr_q.size() == 0) $display("FAIL credit_extra_issue: ptr %0d want none", iss_ptr_o);
                else if (iss_ptr_o !== exp_ptr_q[0]) $display("FAIL credit_order: ptr %0d want %0d", iss_ptr_o, exp_ptr_q[0]);
                else begin n_pass++; void'(exp_ptr_q.pop_front()); end
            end
        end
        n_checks++;
        if (exp_ptr_q.size() != 0) $display("FAIL credit_first_four: %0d missing want 0", exp_ptr_q.size()); else n_pass++;
        n_checks++;
        if (occupancy_o !== 4'd2) $display("FAIL credit_held: occupancy %0d want 2", occupancy_o); else n_pass++;
        exp_ptr_q.push_back(3'd4);
        exp_ptr_q.push_back(3'd5);
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk_i);
            idle();
            if (cyc < 2) credit_release_i = 3'b010;
            #1;
            if (iss_valid_o) begin
                n_checks++;
                if (exp_ptr_q.size() == 0) $display("FAIL credit_extra_release_issue: ptr %0d want none", iss_ptr_o);
                else if (iss_ptr_o !== exp_ptr_q[0]) $display("FAIL credit_release_order: ptr %0d want %0d", iss_ptr_o, exp_ptr_q[0]);
                else begin n_pass++; void'(exp_ptr_q.pop_front()); end
            end
        end
        n_checks++;
        if (exp_ptr_q.size() != 0) $display("FAIL credit_release_issue: %0d missing want 0", exp_ptr_q.size()); else n_pass++;
        wait_empty("credit");
    endtask

    task automatic test_linefill();
        apply_reset();
        iss_ready_i = 1'b1;
        @(negedge clk_i);
        drive_req(OP_RD_LF, 2'd0, 20'h300, 1'b1, 6'd5);
        @(negedge clk_i);
        drive_req(OP_WR, 2'd0, 20'h301, 1'b0, '0);
        #1;
        n_checks++;
        if (iss_valid_o !== 1'b0) $display("FAIL lf_wait_blocks: valid %b want 0", iss_valid_o); else n_pass++;
        @(negedge clk_i);
        idle();
        #1;
        n_checks++;
        if ({iss_valid_o, iss_ptr_o, iss_payload_o} !== {1'b1, 3'd1, 20'h301})
            $display("FAIL lf_write_first: valid/ptr/payload %b/%0d/%h want 1/1/301", iss_valid_o, iss_ptr_o, iss_payload_o);
        else n_pass++;
        @(negedge clk_i);
        idle();
        biu_rvalid_i = 1'b1;
        biu_rid_i = 6'd5;
        #1;
        n_checks++;
        if (iss_valid_o !== 1'b0) $display("FAIL lf_before_return: valid %b want 0", iss_valid_o); else n_pass++;
        @(negedge clk_i);
        idle();
        #1;
        n_checks++;
        if ({iss_valid_o, iss_ptr_o, iss_op_o, iss_payload_o} !== {1'b1, 3'd0, 2'd2, 20'h300})
            $display("FAIL lf_after_return: valid/ptr/op/payload %b/%0d/%0d/%h want 1/0/2/300",
                     iss_valid_o, iss_ptr_o, iss_op_o, iss_payload_o);
        else n_pass++;
        n_checks++;
        if (occupancy_o !== 4'd2) $display("FAIL lf_occ: got %0d want 2", occupancy_o); else n_pass++;
        wait_empty("lf");
        @(negedge clk_i);
        drive_req(OP_RD_LF, 2'd0, 20'h302, 1'b1, 6'd9);
        biu_rvalid_i = 1'b1;
        biu_rid_i = 6'd9;
        @(negedge clk_i);
        idle();
        #1;
        n_checks++;
        if ({iss_valid_o, iss_ptr_o, iss_payload_o} !== {1'b1, 3'd2, 20'h302})
            $display("FAIL lf_same_cycle_return: valid/ptr/payload %b/%0d/%h want 1/2/302", iss_valid_o, iss_ptr_o, iss_payload_o);
        else n_pass++;
    endtask

    task automatic test_evict();
        int fires;
        logic held_bad;
        apply_reset();
        iss_ready_i = 1'b1;
        fires = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (i < 4) drive_req(OP_RD, 2'd2, PAYLOAD_WIDTH'(32'h400 + i), 1'b0, '0);
            else drive_req(OP_WB, 2'd2, 20'h404, 1'b1, 6'd7);
            #1;
            if (iss_valid_o) fires++;
        end
        n_checks++;
        if (fires != 4) $display("FAIL evict_drain_credit: issues %0d want 4", fires); else n_pass++;
        @(negedge clk_i);
        drive_req(OP_RD, 2'd2, 20'h405, 1'b0, '0);
        #1;
        n_checks++;
        if ({iss_valid_o, iss_ptr_o, iss_op_o, iss_ch_id_o} !== {1'b1, 3'd4, 2'd3, 2'd2})
            $display("FAIL evict_issue: valid/ptr/op/ch %b/%0d/%0d/%0d want 1/4/3/2", iss_valid_o, iss_ptr_o, iss_op_o, iss_ch_id_o);
        else n_pass++;
        held_bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            idle();
            #1;
            if (iss_valid_o) held_bad = 1'b1;
        end
        n_checks++;
        if (held_bad !== 1'b0) $display("FAIL evict_credit_unchanged: read issued %b want 0", held_bad); else n_pass++;
        @(negedge clk_i);
        credit_release_i = 3'b100;
        #1;
        n_checks++;
        if (iss_valid_o !== 1'b0) $display("FAIL evict_release_latency: valid %b want 0", iss_valid_o); else n_pass++;
        @(negedge clk_i);
        idle();
        #1;
        n_checks++;
        if ({iss_valid_o, iss_ptr_o, iss_payload_o} !== {1'b1, 3'd5, 20'h405})
            $display("FAIL evict_read_after_release: valid/ptr/payload %b/%0d/%h want 1/5/405", iss_valid_o, iss_ptr_o, iss_payload_o);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic                 w_tab[7]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [RID_WIDTH-1:0] rid_tab[7] = '{6'd1, 6'd2, 6'd0, 6'd3, 6'd4, 6'd10, 6'd0};
        apply_reset();
        iss_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            drive_req(OP_WR, 2'd0, PAYLOAD_WIDTH'(i), 1'b0, '0);
        end
        @(negedge clk_i);
        idle();
        wait_empty("wrap_setup");
        iss_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            drive_req(OP_WR, 2'd0, PAYLOAD_WIDTH'(32'h500 + i), w_tab[i], rid_tab[i]);
        end
        @(negedge clk_i);
        idle();
        iss_ready_i = 1'b1;
        #1;
        n_checks++;
        if (occupancy_o !== 4'd7) $display("FAIL wrap_occ: got %0d want 7", occupancy_o); else n_pass++;
        n_checks++;
        if ({iss_valid_o, iss_ptr_o, iss_payload_o} !== {1'b1, 3'd5, 20'h502})
            $display("FAIL wrap_oldest: valid/ptr/payload %b/%0d/%h want 1/5/502", iss_valid_o, iss_ptr_o, iss_payload_o);
        else n_pass++;
        @(negedge clk_i);
        biu_rvalid_i = 1'b1;
        biu_rid_i = 6'd10;
        #1;
        n_checks++;
        if ({iss_valid_o, iss_ptr_o, iss_payload_o} !== {1'b1, 3'd1, 20'h506})
            $display("FAIL wrap_second: valid/ptr/payload %b/%0d/%h want 1/1/506", iss_valid_o, iss_ptr_o, iss_payload_o);
        else n_pass++;
        @(negedge clk_i);
        idle();
        #1;
        n_checks++;
        if ({iss_valid_o, iss_ptr_o, iss_payload_o} !== {1'b1, 3'd0, 20'h505})
            $display("FAIL wrap_slot0: valid/ptr/payload %b/%0d/%h want 1/0/505", iss_valid_o, iss_ptr_o, iss_payload_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int fires;
        apply_reset();
        iss_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            drive_req(OP_RD, 2'd0, PAYLOAD_WIDTH'(32'h600 + i), 1'b0, '0);
        end
        @(negedge clk_i);
        idle();
        wait_empty("rst_setup");
        iss_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            drive_req(OP_WR, 2'd1, PAYLOAD_WIDTH'(32'h700 + i), 1'b0, '0);
        end
        @(negedge clk_i);
        idle();
        #1;
        n_checks++;
        if (occupancy_o !== 4'd5) $display("FAIL rst_mid_pre_occ: got %0d want 5", occupancy_o); else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        iss_ready_i = 1'b1;
        #1;
        n_checks++;
        if ({iss_valid_o, req_ready_o, occupancy_o} !== {1'b0, 1'b1, 4'd0})
            $display("FAIL rst_mid_outputs: valid/ready/occ %b/%b/%0d want 0/1/0", iss_valid_o, req_ready_o, occupancy_o);
        else n_pass++;
        fires = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk_i);
            if (cyc < 5) drive_req(OP_RD, 2'd0, PAYLOAD_WIDTH'(32'h800 + cyc), 1'b0, '0);
            else idle();
            #1;
            if (iss_valid_o) fires++;
        end
        n_checks++;
        if (fires != CREDIT_MAX) $display("FAIL rst_mid_credits_full: issues %0d want %0d", fires, CREDIT_MAX); else n_pass++;
    endtask

    initial begin
        rst_i = 1'b1;
        iss_ready_i = 1'b0;
        idle();
        test_reset();
        test_back_to_back();
        test_credits();
        test_linefill();
        test_evict();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
